// File: rtl/dmem_access_pkg.sv
// Shared op codes, FSM state encodings and helpers for the DMEM access sequencer.
package dmem_access_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_INC   = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_WRITE  = 2'b10,
    S_RESP   = 2'b11
  } state_e;

  // Ops that sample DMEM during ACCESS.
  function automatic logic is_read_op(input op_e op);
    return (op == OP_LOAD) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/dmem_access_ctrl.sv
// Memory-stage sequencer: one LOAD/STORE/INC request in flight between execute,
// the 8-bit DMEM and writeback, with address bounds checking.
module dmem_access_ctrl
  import dmem_access_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_read,
  output logic              dmem_write,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   data_q;
  logic                err_q;
  logic                accept;
  logic                req_err;

  assign accept  = (state_q == S_IDLE) && req_valid;
  assign req_err = ({1'b0, req_addr} >= DEPTH_EXT) || (op_e'(req_op) == OP_RSVD);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req_valid) state_d = S_ACCESS;
      S_ACCESS: begin
        if (!err_q && op_q == OP_INC) state_d = S_WRITE;
        else                          state_d = S_RESP;
      end
      S_WRITE:  state_d = S_RESP;
      S_RESP:   if (resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= op_e'(req_op);
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
      // STORE and errored requests report zero data.
      if (state_q == S_ACCESS)
        data_q <= (!err_q && is_read_op(op_q)) ? dmem_rdata : '0;
    end
  end

  always_comb begin
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    unique case (state_q)
      S_ACCESS: begin
        dmem_addr = addr_q;
        if (!err_q) begin
          dmem_read = is_read_op(op_q);
          if (op_q == OP_STORE) begin
            dmem_write = 1'b1;
            dmem_wdata = wdata_q;
          end
        end
      end
      S_WRITE: begin
        dmem_addr  = addr_q;
        dmem_write = 1'b1;
        dmem_wdata = data_q + wdata_q;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = resp_valid ? data_q : '0;
  assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural 32-word DMEM.
module tb_dmem_access_ctrl;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] dmem_addr;
  logic [7:0] dmem_wdata;
  logic       dmem_read;
  logic       dmem_write;
  logic [7:0] dmem_rdata;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
  logic       resp_err;

  logic [7:0] mem [0:31];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic mon_en  = 1'b0;
  logic mon_hit = 1'b0;

  dmem_access_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .dmem_rdata (dmem_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dmem_rdata = (dmem_addr < 8'd32) ? mem[dmem_addr[4:0]] : 8'h00;

  always @(posedge clk)
    if (dmem_write && dmem_addr < 8'd32) mem[dmem_addr[4:0]] <= dmem_wdata;

  always @(negedge clk)
    if (mon_en && (dmem_read || dmem_write)) mon_hit <= 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input string tag, input logic [1:0] op, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_data,
                        input logic exp_err, input int unsigned exp_lat);
    int unsigned n;
    logic exp_rd, exp_wr;
    exp_rd = !exp_err && (op == 2'b00 || op == 2'b10);
    exp_wr = !exp_err && (op == 2'b01);
    n = 0;
    while (!req_ready && n < 10) begin step(); n++; end
    check({tag, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    resp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    #1;
    check({tag, "_rd"}, dmem_read, exp_rd);
    check({tag, "_wr"}, dmem_write, exp_wr);
    if (!exp_err) check({tag, "_addr"}, dmem_addr, addr);
    n = 1;
    while (!resp_valid && n < 10) begin step(); n++; end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_data"}, resp_data, exp_data);
    check({tag, "_err"}, resp_err, exp_err);
    step();
    check({tag, "_done"}, resp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]      = 8'(i);
      mem[16 + i] = 8'(-i);
    end
    reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1;
    step(); step();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_dmem_rw", {dmem_read, dmem_write}, 2'b00);
    check("rst_dmem_addr", dmem_addr, 8'h00);
    check("rst_resp_data", {resp_err, resp_data}, 9'h000);
    reset = 1'b1;
    step();

    // Loads, store, read-modify-write increments with wrap
    do_req("ld5",   2'b00, 8'd5,  8'h00, 8'h05, 1'b0, 2);
    do_req("ld17",  2'b00, 8'd17, 8'h00, 8'hFF, 1'b0, 2);
    do_req("st3",   2'b01, 8'd3,  8'hA5, 8'h00, 1'b0, 2);
    check("mem3", mem[3], 8'hA5);
    do_req("ld3",   2'b00, 8'd3,  8'h00, 8'hA5, 1'b0, 2);
    do_req("inc2",  2'b10, 8'd2,  8'h10, 8'h02, 1'b0, 3);
    do_req("ld2",   2'b00, 8'd2,  8'h00, 8'h12, 1'b0, 2);
    do_req("inc31", 2'b10, 8'd31, 8'h20, 8'hF1, 1'b0, 3);
    do_req("ld31",  2'b00, 8'd31, 8'h00, 8'h11, 1'b0, 2);

    // Errors: out of range and reserved op must not touch DMEM
    mon_en = 1'b1;
    do_req("ld32",  2'b00, 8'd32, 8'h00, 8'h00, 1'b1, 2);
    do_req("rsvd",  2'b11, 8'd0,  8'h55, 8'h00, 1'b1, 2);
    do_req("inc40", 2'b10, 8'd40, 8'h01, 8'h00, 1'b1, 2);
    mon_en = 1'b0;
    check("err_no_dmem", mon_hit, 1'b0);
    check("mem0", mem[0], 8'h00);

    // Backpressure on the response while a new request waits
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'b00; req_addr = 8'd5; req_wdata = 8'h00;
    step();
    req_addr = 8'd2;
    step();
    check("bp_valid0", resp_valid, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_valid", resp_valid, 1'b1);
      check("bp_data", resp_data, 8'h05);
      check("bp_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    step();
    check("bp_hs_valid", resp_valid, 1'b0);
    check("bp_hs_ready", req_ready, 1'b1);
    step();
    check("bp_accept", req_ready, 1'b0);
    req_valid = 1'b0;
    step();
    check("bp2_valid", resp_valid, 1'b1);
    check("bp2_data", resp_data, 8'h12);
    step();

    // Reset during the WRITE phase of INC
    req_valid = 1'b1; req_op = 2'b10; req_addr = 8'd4; req_wdata = 8'h07;
    step();
    req_valid = 1'b0;
    step();
    check("rw_write", dmem_write, 1'b1);
    check("rw_wdata", dmem_wdata, 8'h0B);
    #2 reset = 1'b0;
    #1;
    check("rw_rst_write", dmem_write, 1'b0);
    check("rw_rst_ready", req_ready, 1'b1);
    check("rw_rst_valid", resp_valid, 1'b0);
    step(); step();
    check("rw_mem4", mem[4], 8'h04);
    reset = 1'b1;
    step();
    do_req("ld4", 2'b00, 8'd4, 8'h00, 8'h04, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
